// File: rtl/f_div_pkg.sv
// Shared defaults, button bit-index helpers and saturating ratio arithmetic for f_div_multi.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package f_div_pkg;

  localparam int F_DIV_NCH          = 2;
  localparam int F_DIV_CW           = 16;
  localparam int F_DIV_INIT         = 4;
  localparam int F_DIV_MIN          = 1;
  localparam int F_DIV_MAX          = 1000;
  localparam int F_DIV_STEP         = 1;
  localparam int F_DIV_DEBOUNCE_CYC = 8;

  // Each channel owns two consecutive button bits: up then down.
  localparam int BTN_UP     = 0;
  localparam int BTN_DN     = 1;
  localparam int BTN_PER_CH = 2;

  // Ratio arithmetic is done one bit wider than any supported CW (up to 32),
  // so an add or subtract can never wrap before saturation is applied.
  localparam int SAT_W = 33;
  typedef logic [SAT_W-1:0] sat_t;

  function automatic int btn_up_idx(input int ch);
    return BTN_PER_CH * ch + BTN_UP;
  endfunction

  function automatic int btn_dn_idx(input int ch);
    return BTN_PER_CH * ch + BTN_DN;
  endfunction

  function automatic sat_t sat_add(input sat_t a, input sat_t step, input sat_t hi);
    sat_t s;
    s = a + step;
    return (s > hi) ? hi : s;
  endfunction

  function automatic sat_t sat_sub(input sat_t a, input sat_t step, input sat_t lo);
    return (a >= lo + step) ? (a - step) : lo;
  endfunction

endpackage

// File: rtl/f_div_chan.sv
// One divider channel: button sync/edge detect, pending and active ratio, counter, f_out/tick.
// Latency: pending updates 3 edges after a button rises (+DEBOUNCE_CYC with F_DIV_MULTI_DEBOUNCE_EN); tick is registered.
// Backpressure: none; en=0 freezes the counter and outputs while presses still update pending.
module f_div_chan
  import f_div_pkg::*;
#(
  parameter int CW           = F_DIV_CW,
  parameter int DIV_INIT     = F_DIV_INIT,
  parameter int DIV_MIN      = F_DIV_MIN,
  parameter int DIV_MAX      = F_DIV_MAX,
  parameter int DIV_STEP     = F_DIV_STEP
`ifdef F_DIV_MULTI_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYC = F_DIV_DEBOUNCE_CYC
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          btn_up,
  input  logic          btn_dn,
  output logic          f_out,
  output logic          tick,
  output logic [CW-1:0] div_val
);

  logic [1:0]    sync1, sync2, lvl, lvl_d, press;
  logic [CW-1:0] pending, pending_nxt, active, cnt;
  sat_t          pend_ext;

  // Two-flop synchronizer on both button bits (bit 0 up, bit 1 down).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_dn, btn_up};
      sync2 <= sync1;
    end
  end

`ifdef F_DIV_MULTI_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0]    deb_lvl;
  logic [DW-1:0] deb_cnt [2];

  // Accept a new synchronized level only after it has persisted DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_lvl <= '0;
      for (int b = 0; b < 2; b++) deb_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == deb_lvl[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DW'(DEBOUNCE_CYC - 1)) begin
          deb_lvl[b] <= sync2[b];
          deb_cnt[b] <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + DW'(1);
        end
      end
    end
  end

  assign lvl = deb_lvl;
`else
  assign lvl = sync2;
`endif

  // Delayed level for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lvl_d <= '0;
    else      lvl_d <= lvl;
  end

  assign press    = lvl & ~lvl_d;
  assign pend_ext = sat_t'(pending);

  // Saturating step of the pending ratio; simultaneous up and down cancel.
  always_comb begin
    pending_nxt = pending;
    if (press == 2'b01)
      pending_nxt = CW'(sat_add(pend_ext, sat_t'(DIV_STEP), sat_t'(DIV_MAX)));
    else if (press == 2'b10)
      pending_nxt = CW'(sat_sub(pend_ext, sat_t'(DIV_STEP), sat_t'(DIV_MIN)));
  end

  // Pending ratio register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= CW'(DIV_INIT);
    else      pending <= pending_nxt;
  end

  // Half-period counter; the wrap toggles f_out, pulses tick and adopts the pending ratio.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      f_out  <= 1'b0;
      tick   <= 1'b0;
      active <= CW'(DIV_INIT);
    end else if (en) begin
      if (cnt == active - CW'(1)) begin
        cnt    <= '0;
        f_out  <= ~f_out;
        tick   <= 1'b1;
        active <= pending;
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  assign div_val = active;

endmodule

// File: rtl/f_div_multi.sv
// NCH independent button-adjustable clock dividers (optional debounce: F_DIV_MULTI_DEBOUNCE_EN).
// Latency: ratio change visible on div_val at the first wrap after pending updates (3 edges after press).
// Backpressure: none; en is a global count enable.
module f_div_multi
  import f_div_pkg::*;
#(
  parameter int NCH          = F_DIV_NCH,
  parameter int CW           = F_DIV_CW,
  parameter int DIV_INIT     = F_DIV_INIT,
  parameter int DIV_MIN      = F_DIV_MIN,
  parameter int DIV_MAX      = F_DIV_MAX,
  parameter int DIV_STEP     = F_DIV_STEP,
  parameter int DEBOUNCE_CYC = F_DIV_DEBOUNCE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2*NCH-1:0]  button,
  output logic [NCH-1:0]    f_out,
  output logic [NCH-1:0]    tick,
  output logic [NCH*CW-1:0] div_val
);

  // One self-contained channel per divider.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    f_div_chan #(
      .CW       (CW),
      .DIV_INIT (DIV_INIT),
      .DIV_MIN  (DIV_MIN),
      .DIV_MAX  (DIV_MAX),
      .DIV_STEP (DIV_STEP)
`ifdef F_DIV_MULTI_DEBOUNCE_EN
      , .DEBOUNCE_CYC (DEBOUNCE_CYC)
`endif
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .btn_up  (button[btn_up_idx(i)]),
      .btn_dn  (button[btn_dn_idx(i)]),
      .f_out   (f_out[i]),
      .tick    (tick[i]),
      .div_val (div_val[i*CW +: CW])
    );
  end

endmodule

// File: tb/tb_f_div_multi.sv
// Self-checking bench for f_div_multi with a cycle-level behavioural reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_f_div_multi;

  localparam int NCH   = 2;
  localparam int CW    = 8;
  localparam int DINIT = 4;
  localparam int DMIN  = 1;
  localparam int DMAX  = 10;
  localparam int DSTEP = 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                en  = 1'b1;
  logic [2*NCH-1:0]    button = '0;
  logic [NCH-1:0]      f_out, tick;
  logic [NCH*CW-1:0]   div_val;

  int n_cmp = 0;
  int n_bad = 0;
  int g;

  always #5 clk = ~clk;

  f_div_multi #(
    .NCH(NCH), .CW(CW), .DIV_INIT(DINIT), .DIV_MIN(DMIN), .DIV_MAX(DMAX),
    .DIV_STEP(DSTEP), .DEBOUNCE_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .button(button),
    .f_out(f_out), .tick(tick), .div_val(div_val)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: press happens when a button was first seen high two
  // edges ago; ratios saturate; a channel wraps after 'active' enabled cycles.
  int m_pend [NCH];
  int m_act  [NCH];
  int m_ph   [NCH];
  bit m_f    [NCH];
  bit m_t    [NCH];
  bit h      [2*NCH][4];
  bit pr     [2*NCH];

  always @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_pend[c] = DINIT; m_act[c] = DINIT; m_ph[c] = 0; m_f[c] = 0; m_t[c] = 0;
      end
      for (int b = 0; b < 2*NCH; b++)
        for (int k = 0; k < 4; k++) h[b][k] = 0;
    end else begin
      for (int b = 0; b < 2*NCH; b++) begin
        h[b][3] = h[b][2]; h[b][2] = h[b][1]; h[b][1] = h[b][0]; h[b][0] = button[b];
        pr[b] = h[b][2] && !h[b][3];
      end
      for (int c = 0; c < NCH; c++) begin
        if (en) begin
          if (m_ph[c] == m_act[c] - 1) begin
            m_ph[c] = 0; m_t[c] = 1; m_f[c] = !m_f[c]; m_act[c] = m_pend[c];
          end else begin
            m_ph[c]++; m_t[c] = 0;
          end
        end else begin
          m_t[c] = 0;
        end
        if (pr[2*c] && !pr[2*c+1])
          m_pend[c] = (m_pend[c] + DSTEP > DMAX) ? DMAX : m_pend[c] + DSTEP;
        else if (pr[2*c+1] && !pr[2*c])
          m_pend[c] = (m_pend[c] - DSTEP < DMIN) ? DMIN : m_pend[c] - DSTEP;
      end
    end
  end

  // Compare DUT against the model on every out-of-reset cycle.
  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("f_out[%0d]", c), int'(f_out[c]), int'(m_f[c]));
        check($sformatf("tick[%0d]", c), int'(tick[c]), int'(m_t[c]));
        check($sformatf("div_val[%0d]", c), int'(div_val[c*CW +: CW]), m_act[c]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int b);
    button[b] = 1'b1;
    cyc(1);
    button[b] = 1'b0;
    cyc(1);
  endtask

  // Cycles between two consecutive tick pulses; -1 on timeout.
  task automatic tick_gap(input int ch, output int gap);
    int k;
    gap = -1;
    k = 0;
    while (!tick[ch] && k < 40) begin cyc(1); k++; end
    if (!tick[ch]) return;
    k = 0;
    do begin cyc(1); k++; end while (!tick[ch] && k < 40);
    if (tick[ch]) gap = k;
  endtask

  // Cycles between two consecutive f_out edges (half period); -1 on timeout.
  task automatic tog_gap(input int ch, output int gap);
    int k;
    logic v;
    gap = -1;
    v = f_out[ch];
    k = 0;
    while (f_out[ch] == v && k < 40) begin cyc(1); k++; end
    if (f_out[ch] == v) return;
    v = f_out[ch];
    k = 0;
    do begin cyc(1); k++; end while (f_out[ch] == v && k < 40);
    if (f_out[ch] != v) gap = k;
  endtask

  initial begin
    int k;
    rst = 1'b0; en = 1'b1; button = '0;
    cyc(3);
    check("rst_f_out", int'(f_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_div_val", int'(div_val), 16'h0404);
    rst = 1'b1;

    // Default ratio: half period 4 on both channels.
    tick_gap(0, g); check("init_tick_gap0", g, 4);
    tick_gap(1, g); check("init_tick_gap1", g, 4);
    tog_gap(0, g);  check("init_half_per0", g, 4);
    tog_gap(1, g);  check("init_half_per1", g, 4);
    check("init_div_val", int'(div_val), 16'h0404);
    check("model_init_act0", m_act[0], 4);

    // One up press on channel 0.
    press(0);
    cyc(12);
    check("up_div0", int'(div_val[7:0]), 5);
    check("model_up_act0", m_act[0], 5);
    tick_gap(0, g); check("up_tick_gap0", g, 5);
    tog_gap(0, g);  check("up_half_per0", g, 5);
    tick_gap(1, g); check("up_tick_gap1_untouched", g, 4);

    // Saturation on channel 1, upwards then downwards.
    repeat (8) press(2);
    cyc(25);
    check("sat_hi_div1", int'(div_val[15:8]), 10);
    check("model_sat_hi_pend1", m_pend[1], 10);
    tick_gap(1, g); check("sat_hi_tick_gap1", g, 10);
    repeat (12) press(3);
    cyc(25);
    check("sat_lo_div1", int'(div_val[15:8]), 1);
    tog_gap(1, g);  check("sat_lo_half_per1", g, 1);
    check("sat_ch0_untouched", int'(div_val[7:0]), 5);

    // Simultaneous up and down on channel 0 cancel.
    rst = 1'b0; cyc(2); rst = 1'b1;
    button[1:0] = 2'b11; cyc(2); button[1:0] = 2'b00;
    cyc(15);
    check("both_div0", int'(div_val[7:0]), 4);
    check("model_both_pend0", m_pend[0], 4);

    // Global enable low for 7 cycles mid-count.
    cyc(2);
    en = 1'b0;
    repeat (7) begin
      cyc(1);
      check("en0_tick", int'(tick), 0);
    end
    en = 1'b1;
    cyc(12);

    // Reset between a press and the next wrap.
    press(0);
    cyc(2);
    check("model_prerst_pend0", m_pend[0], 5);
    rst = 1'b0; cyc(2);
    check("rst2_div_val", int'(div_val), 16'h0404);
    rst = 1'b1;
    k = 0;
    do begin cyc(1); k++; end while (!tick[0] && k < 20);
    check("rst2_first_tick", k, 4);
    check("rst2_div0_after_wrap", int'(div_val[7:0]), 4);

    // Randomized buttons and enable against the model.
    repeat (500) begin
      if ($urandom_range(0, 3) == 0) button = 4'($urandom);
      en = ($urandom_range(0, 7) != 0);
      cyc(1);
    end
    en = 1'b1; button = '0;
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/f_div_multi.md
F_DIV_MULTI -- requirements
Module: f_div_multi

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent divider channels.
REQ-002 SHALL have parameter CW, default 16: width of the divide-ratio and counter registers.
REQ-003 SHALL have parameter DIV_INIT, default 4: divide ratio loaded at reset.
REQ-004 SHALL have parameters DIV_MIN (default 1), DIV_MAX (default 1000) and DIV_STEP (default 1): saturation limits and the increment applied per button press.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: global count enable.
REQ-008 SHALL have port button, input, 2*NCH bits: bit 2i is the up request for channel i; bit 2i+1 is the down request.
REQ-009 SHALL have port f_out, output, NCH bits: divided square wave per channel.
REQ-010 SHALL have port tick, output, NCH bits: one-cycle pulse at each terminal count.
REQ-011 SHALL have port div_val, output, NCH*CW bits: the active divide ratio per channel, channel i at bits [i*CW +: CW].

Function
REQ-012 SHALL pass each button bit through a 2-flop synchronizer and then a rising-edge detector, producing one press pulse per 0->1 transition.
REQ-013 SHALL update the pending ratio on the 3rd rising clk edge after a button bit rises, measured from the first edge that samples it high.
REQ-014 SHALL set pending = min(pending + DIV_STEP, DIV_MAX) on an up press, and pending = max(pending - DIV_STEP, DIV_MIN) on a down press; arithmetic uses CW+1 bits so it never wraps.
REQ-015 SHALL leave pending unchanged when up and down press pulses occur in the same cycle.
REQ-016 SHALL, per channel, count cnt from 0 to div-1 while en=1, then wrap to 0.
REQ-017 SHALL, on the wrap cycle, assert tick for exactly 1 cycle, toggle f_out, and copy pending into the active ratio (glitch-free: the new ratio applies from the next half-period).
REQ-018 SHALL give f_out a period of 2*div cycles and 50% duty.
REQ-019 SHALL, while en=0, hold cnt and f_out and keep tick at 0; button presses SHALL still update pending.
REQ-020 SHALL drive div_val from the active ratio, not from pending.
REQ-021 SHALL make channels fully independent; a press on one channel SHALL NOT disturb any other channel.

Reset
REQ-022 SHALL, while rst=0 (asynchronous), force: cnt=0, f_out=0, tick=0, pending=DIV_INIT, active ratio=DIV_INIT, synchronizer and edge flops=0.
REQ-023 SHALL, if reset is asserted mid-period, discard any pending change, and the first tick after release SHALL occur DIV_INIT cycles after release (with en=1).
REQ-024 SHALL, when a button is already high at reset release, detect one press once the synchronizer output rises.

Configuration
REQ-025 SHALL, with macro F_DIV_MULTI_DEBOUNCE_EN defined, add per-button debounce: a synchronized level must be stable for DEBOUNCE_CYC cycles (parameter, default 8) before edge detection, which adds DEBOUNCE_CYC cycles to the REQ-013 latency.
REQ-026 SHALL, without F_DIV_MULTI_DEBOUNCE_EN, contain no debounce logic, with timing exactly as in REQ-013, and SHALL ignore DEBOUNCE_CYC.

Structure
REQ-027 SHALL place the parameter defaults, the button bit-index helpers (UP=0, DN=1) and the saturating add/subtract functions in shared package f_div_pkg.
REQ-028 SHALL implement one channel (synchronizer, edge detect, pending/active ratio, counter, outputs) in sub-module f_div_chan, instantiated NCH times by a generate loop.

Verification
Settings for all scenarios: NCH=2, CW=8, DIV_INIT=4, DIV_MIN=1, DIV_MAX=10, DIV_STEP=1, en=1, macro off.
REQ-029 SHALL check reset release with no presses -> f_out of both channels toggles every 4 cycles (period 8); tick fires every 4 cycles; div_val={4,4}.
REQ-030 SHALL check button[0] pulsed for 1 cycle -> channel 0 pending=5 after 3 edges, div_val[7:0]=5 at the next wrap, then period 10; channel 1 stays at period 8.
REQ-031 SHALL check 8 up presses on channel 1 -> div_val[15:8] saturates at 10 (not 11 or 12); then 12 down presses -> saturates at 1, giving f_out period 2.
REQ-032 SHALL check button[1:0]=2'b11 raised in the same cycle -> channel 0 ratio unchanged at 4.
REQ-033 SHALL check en=0 for 7 cycles mid-count -> f_out frozen, tick=0, and after en=1 the count resumes from the held cnt value.
REQ-034 SHALL check rst=0 asserted between a press and the next wrap -> div_val returns to 4 and the first tick occurs 4 cycles after release.
